vending_param: RTL and testbench

VENDING_PARAM -- requirements
Module: vending_param

---
 rtl/vend_pkg.sv | 26 ++
 rtl/vend_change_out.sv | 34 +++
 rtl/vending_param.sv | 110 +++++++++++
 tb/tb_vending_param.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types for the vending controller: coin codes, FSM states and coin valuation.
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10,
    COIN_25   = 2'b11
  } coin_e;

  typedef enum logic {
    IDLE   = 1'b0,
    PAYOUT = 1'b1
  } state_e;

  // Coin code to value in 5-cent units.
  function automatic logic [2:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_5:  coin_value = 3'd1;
      COIN_10: coin_value = 3'd2;
      COIN_25: coin_value = 3'd5;
      default: coin_value = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_out.sv
// Change payout down-counter: emits one 10c or 5c coin per active cycle until empty.
module vend_change_out #(
  parameter int CREDIT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                active,
  input  logic                load,
  input  logic [CREDIT_W-1:0] load_val,
  output logic                chg5,
  output logic                chg10,
  output logic                last
);

  logic [CREDIT_W-1:0] change_q;

  // Outputs depend only on registered state, so they are clean Moore pulses.
  assign chg10 = active && (change_q >= CREDIT_W'(2));
  assign chg5  = active && (change_q == CREDIT_W'(1));
  assign last  = active && (change_q <= CREDIT_W'(2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      change_q <= '0;
    end else if (load) begin
      change_q <= load_val;
    end else if (chg10) begin
      change_q <= change_q - CREDIT_W'(2);
    end else if (chg5) begin
      change_q <= change_q - CREDIT_W'(1);
    end
  end

endmodule

// File: rtl/vending_param.sv
// Parameterised vending controller with change payout.
// Optional refund-on-cancel is enabled by defining VEND_CANCEL_EN.
module vending_param
  import vend_pkg::*;
#(
  parameter int PRICE_UNITS = 4,
  parameter int CREDIT_W    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                cancel,
  output logic                dispense,
  output logic                chg5,
  output logic                chg10,
  output logic                busy,
  output logic                coin_rej,
  output logic [CREDIT_W-1:0] credit
);

  if ((2 ** CREDIT_W) <= (PRICE_UNITS + 4)) begin : g_credit_w_check
    $error("CREDIT_W too narrow to hold PRICE_UNITS + 4");
  end
  if ((PRICE_UNITS < 1) || (PRICE_UNITS > 31)) begin : g_price_check
    $error("PRICE_UNITS out of range 1..31");
  end

  localparam logic [CREDIT_W:0] PRICE_S = (CREDIT_W+1)'(PRICE_UNITS);

  state_e              state, state_nxt;
  logic [CREDIT_W-1:0] credit_q, credit_nxt;
  logic [CREDIT_W:0]   sum, change_amt;
  logic                load, last, cancel_hit, dispense_c, coin_rej_c;
  logic [CREDIT_W-1:0] load_val;

`ifdef VEND_CANCEL_EN
  assign cancel_hit = cancel && (state == IDLE) && (credit_q != '0);
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign cancel_hit    = 1'b0;
`endif

  assign sum        = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin));
  assign change_amt = sum - PRICE_S;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      credit_q <= '0;
    end else begin
      state    <= state_nxt;
      credit_q <= credit_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit_q;
    load       = 1'b0;
    load_val   = '0;
    dispense_c = 1'b0;
    coin_rej_c = 1'b0;
    case (state)
      IDLE: begin
        if (cancel_hit) begin
          // A coin arriving with cancel is bounced; only prior credit is refunded.
          coin_rej_c = (coin != COIN_NONE);
          load       = 1'b1;
          load_val   = credit_q;
          credit_nxt = '0;
          state_nxt  = PAYOUT;
        end else if (coin != COIN_NONE) begin
          if (sum >= PRICE_S) begin
            dispense_c = 1'b1;
            load       = 1'b1;
            load_val   = change_amt[CREDIT_W-1:0];
            credit_nxt = '0;
            if (change_amt != '0) state_nxt = PAYOUT;
          end else begin
            credit_nxt = sum[CREDIT_W-1:0];
          end
        end
      end
      PAYOUT: begin
        coin_rej_c = (coin != COIN_NONE);
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  vend_change_out #(.CREDIT_W(CREDIT_W)) u_change_out (
    .clk      (clk),
    .rst      (rst),
    .active   (state == PAYOUT),
    .load     (load),
    .load_val (load_val),
    .chg5     (chg5),
    .chg10    (chg10),
    .last     (last)
  );

  // Mealy outputs are gated so reset silences them without waiting for a clock.
  assign dispense = dispense_c & ~rst;
  assign coin_rej = coin_rej_c & ~rst;
  assign busy     = (state == PAYOUT);
  assign credit   = credit_q;

endmodule

// File: tb/tb_vending_param.sv
// Randomised and directed bench for vending_param against a queue-based change model.
module tb_vending_param;

  localparam int PRICE = 4;
  localparam int CW    = 6;

  logic          clk = 1'b0;
  logic          rst, cancel, dispense, chg5, chg10, busy, coin_rej;
  logic [1:0]    coin;
  logic [CW-1:0] credit;

  int errors = 0;
  int checks = 0;
  int m_credit = 0;
  int m_q[$];

  vending_param #(.PRICE_UNITS(PRICE), .CREDIT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .coin     (coin),
    .cancel   (cancel),
    .dispense (dispense),
    .chg5     (chg5),
    .chg10    (chg10),
    .busy     (busy),
    .coin_rej (coin_rej),
    .credit   (credit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cents(input int code);
    case (code)
      1: return 1;
      2: return 2;
      3: return 5;
      default: return 0;
    endcase
  endfunction

  // Change is paid largest coin first: a list of 10c coins then at most one 5c.
  task automatic push_change(input int amt);
    int c = amt;
    while (c > 0) begin
      if (c >= 2) begin m_q.push_back(10); c -= 2; end
      else begin m_q.push_back(5); c -= 1; end
    end
  endtask

  task automatic step(input logic [1:0] c, input logic can, input string tag);
    int  e_disp, e_rej, e_c5, e_c10, e_busy, e_cred, sum;
    bit  can_eff;
    @(negedge clk);
    coin = c;
    cancel = can;
    #1;
    e_busy = (m_q.size() > 0);
    e_cred = m_credit;
    e_disp = 0; e_rej = 0; e_c5 = 0; e_c10 = 0;
    can_eff = 1'b0;
`ifdef VEND_CANCEL_EN
    can_eff = can && (m_credit > 0);
`endif
    if (e_busy != 0) begin
      e_c10 = (m_q[0] == 10);
      e_c5  = (m_q[0] == 5);
      e_rej = (c != 0);
      void'(m_q.pop_front());
    end else if (can_eff) begin
      e_rej = (c != 0);
      push_change(m_credit);
      m_credit = 0;
    end else if (c != 0) begin
      sum = m_credit + cents(int'(c));
      if (sum >= PRICE) begin
        e_disp = 1;
        push_change(sum - PRICE);
        m_credit = 0;
      end else begin
        m_credit = sum;
      end
    end
    check({tag, ".dispense"}, dispense, e_disp);
    check({tag, ".coin_rej"}, coin_rej, e_rej);
    check({tag, ".chg5"}, chg5, e_c5);
    check({tag, ".chg10"}, chg10, e_c10);
    check({tag, ".busy"}, busy, e_busy);
    check({tag, ".credit"}, credit, e_cred);
    check({tag, ".chg_excl"}, chg5 & chg10, 0);
    check({tag, ".disp_busy"}, dispense & busy, 0);
  endtask

  task automatic reset_mid(input string tag);
    @(negedge clk);
    coin = 2'b10;
    cancel = 1'b0;
    rst = 1'b1;
    #1;
    check({tag, ".rst_out"}, {dispense, chg5, chg10, busy, coin_rej}, 0);
    check({tag, ".rst_credit"}, credit, 0);
    m_credit = 0;
    m_q.delete();
    @(negedge clk);
    check({tag, ".rst_hold"}, {dispense, chg5, chg10, busy, coin_rej}, 0);
    coin = 2'b00;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    coin = 2'b00;
    cancel = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset.out", {dispense, chg5, chg10, busy, coin_rej}, 0);
    check("reset.credit", credit, 0);
    @(negedge clk);
    rst = 1'b0;

    // 10c + 10c: exact price
    step(2'b10, 1'b0, "a1"); step(2'b10, 1'b0, "a2"); step(2'b00, 1'b0, "a3");
    // 5c + 25c: one 10c change
    step(2'b01, 1'b0, "b1"); step(2'b11, 1'b0, "b2");
    step(2'b00, 1'b0, "b3"); step(2'b00, 1'b0, "b4");
    // 25c from zero: one 5c change
    step(2'b11, 1'b0, "c1"); step(2'b00, 1'b0, "c2"); step(2'b00, 1'b0, "c3");
    // 5c + 10c + cancel: refund 10c then 5c when enabled, ignored otherwise
    step(2'b01, 1'b0, "d1"); step(2'b10, 1'b0, "d2"); step(2'b00, 1'b1, "d3");
    step(2'b00, 1'b0, "d4"); step(2'b00, 1'b0, "d5"); step(2'b00, 1'b0, "d6");
    // cancel with coin, and cancel at zero credit
    step(2'b00, 1'b1, "d7"); step(2'b01, 1'b0, "d8"); step(2'b10, 1'b1, "d9");
    step(2'b00, 1'b0, "d10"); step(2'b00, 1'b0, "d11");
    // coin during a two-coin payout is rejected
    step(2'b01, 1'b0, "e1"); step(2'b10, 1'b0, "e2"); step(2'b11, 1'b0, "e3");
    step(2'b10, 1'b0, "e4"); step(2'b00, 1'b0, "e5"); step(2'b00, 1'b0, "e6");
    // reset in the middle of a payout
    step(2'b01, 1'b0, "f1"); step(2'b10, 1'b0, "f2"); step(2'b11, 1'b0, "f3");
    step(2'b00, 1'b0, "f4");
    reset_mid("f5");
    step(2'b00, 1'b0, "f6"); step(2'b00, 1'b0, "f7");

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 59) == 0) reset_mid("rnd_rst");
      else step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
